// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the AXI4-Lite memory responder: response codes,
// FSM state encodings and the default memory base address.
package ysyx_22050019_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/ysyx_22050019_sram_1r1w.sv
// Word array with one synchronous read port and one byte-masked synchronous
// write port. A read and a write to the same word on the same edge return the
// old contents (read-before-write).
module ysyx_22050019_sram_1r1w #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Registered read; the output holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    // Byte-lane write; only lanes with their strobe set are updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22050019_axil_mem_slave.sv
// AXI4-Lite responder in front of a word-addressed SRAM. Independent read and
// write FSMs, each with a programmable latency, one outstanding transaction
// per direction, and SLVERR for addresses outside the backed window.
module ysyx_22050019_axil_mem_slave
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp
);

    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(DEPTH) << 3;
    localparam logic [3:0]        RD_CNT_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0]        WR_CNT_INIT = 4'(WR_LAT - 1);

    // Read channel state
    rd_state_e            r_state, r_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [3:0]           r_cnt;
    logic                 r_err;
    logic [ADDR_W-1:0]    r_off;
    logic                 r_in_range;
    logic [IDX_W-1:0]     r_idx;

    // Write channel state
    wr_state_e            w_state, w_next;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;
    logic [DATA_W/8-1:0]  w_strb;
    logic                 aw_held, w_held, aw_take, w_take;
    logic [3:0]           w_cnt;
    logic                 w_err;
    logic [ADDR_W-1:0]    w_off;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;

    logic                 sram_rd_en, sram_wr_en;
    logic [DATA_W-1:0]    sram_rd_data;

    // Unsigned offset from the base: addresses below the base wrap to huge
    // values and therefore fall outside the window.
    assign r_off      = r_addr - BASE_ADDR;
    assign r_in_range = r_off < SPAN;
    assign r_idx      = r_off[IDX_W+2:3];
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = w_off < SPAN;
    assign w_idx      = w_off[IDX_W+2:3];

    assign s_axi_rdata = (r_state == R_RESP && !r_err) ? sram_rd_data : '0;
    assign s_axi_rresp = (r_state == R_RESP && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_bresp = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;

    ysyx_22050019_sram_1r1w #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk     (clk),
        .rd_en   (sram_rd_en),
        .rd_idx  (r_idx),
        .rd_data (sram_rd_data),
        .wr_en   (sram_wr_en),
        .wr_idx  (w_idx),
        .wr_data (w_data),
        .wr_strb (w_strb)
    );

    // Read FSM state, latched address, latency countdown and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && s_axi_arvalid) begin
                r_addr <= s_axi_araddr;
                r_cnt  <= RD_CNT_INIT;
            end
            if (r_state == R_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_err <= !r_in_range;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    // Read FSM next state, handshake outputs and the SRAM read strobe.
    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        sram_rd_en    = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_WAIT;
            end
            R_WAIT: begin
                if (r_cnt == 4'd0) begin
                    sram_rd_en = r_in_range;
                    r_next     = R_RESP;
                end
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write FSM state, AW/W holding registers, latency countdown and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_take) begin
                w_addr  <= s_axi_awaddr;
                aw_held <= 1'b1;
            end
            if (w_take) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
                w_held <= 1'b1;
            end
            if (w_state == W_IDLE && w_next == W_WAIT) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                w_cnt   <= WR_CNT_INIT;
            end
            if (w_state == W_WAIT) begin
                if (w_cnt == 4'd0) begin
                    w_err <= !w_in_range;
                end else begin
                    w_cnt <= w_cnt - 4'd1;
                end
            end
        end
    end

    // Write FSM next state, handshake outputs and the commit strobe; a reset
    // landing on the commit edge suppresses the write.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        sram_wr_en    = 1'b0;
        aw_take       = 1'b0;
        w_take        = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = !aw_held;
                s_axi_wready  = !w_held;
                aw_take       = s_axi_awvalid && !aw_held;
                w_take        = s_axi_wvalid && !w_held;
                if ((aw_held || aw_take) && (w_held || w_take)) w_next = W_WAIT;
            end
            W_WAIT: begin
                if (w_cnt == 4'd0) begin
                    sram_wr_en = w_in_range && !rst;
                    w_next     = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050019_axil_mem_slave.sv
// Randomised self-checking bench for the AXI4-Lite memory responder. A plain
// array in the bench mirrors the memory contents from the byte-strobe rules.
module tb_ysyx_22050019_axil_mem_slave;

    localparam int          ADDR_W = 64;
    localparam int          DATA_W = 64;
    localparam int          DEPTH  = 64;
    localparam int          RD_LAT = 2;
    localparam int          WR_LAT = 2;
    localparam logic [63:0] BASE   = 64'h8000_0000;

    logic                 clk;
    logic                 rst;
    logic                 arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0]    araddr;
    logic [DATA_W-1:0]    rdata;
    logic [1:0]           rresp;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic [ADDR_W-1:0]    awaddr;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W/8-1:0]  wstrb;
    logic [1:0]           bresp;

    int checks = 0;
    int errors = 0;
    logic [63:0] model [DEPTH];

    ysyx_22050019_axil_mem_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the window is [BASE, BASE + DEPTH*8), word = offset/8.
    function automatic logic model_in_range(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return off < 64'(DEPTH * 8);
    endfunction

    function automatic int model_idx(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return int'(off / 8);
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        if (model_in_range(a)) begin
            for (int b = 0; b < 8; b++) begin
                if (s[b]) model[model_idx(a)][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    // All tasks start and end 1ns after a rising edge.
    task automatic do_read(input logic [63:0] a, output logic [63:0] d,
                           output logic [1:0] r, output int lat);
        int guard;
        guard = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!rvalid) begin
            checks++; errors++;
            $display("[TB] FAIL read_timeout: rvalid=%0b required 1", rvalid);
        end
        d = rdata;
        r = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int aw_start, input int w_start,
                            output logic [1:0] r, output int lat);
        logic aw_done, w_done, aw_hs, w_hs;
        int k;
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && k < 50) begin
            awvalid = !aw_done && (k >= aw_start);
            wvalid  = !w_done && (k >= w_start);
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
            k++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 0;
        while (!bvalid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!bvalid) begin
            checks++; errors++;
            $display("[TB] FAIL write_timeout: bvalid=%0b required 1", bvalid);
        end
        r = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 8;
        if (arready !== 1'b1) begin errors++; $display("[TB] FAIL reset_arready: got %b want 1", arready); end
        if (awready !== 1'b1) begin errors++; $display("[TB] FAIL reset_awready: got %b want 1", awready); end
        if (wready  !== 1'b1) begin errors++; $display("[TB] FAIL reset_wready: got %b want 1", wready); end
        if (rvalid  !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
        if (bvalid  !== 1'b0) begin errors++; $display("[TB] FAIL reset_bvalid: got %b want 0", bvalid); end
        if (rdata   !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        if (rresp   !== 2'b00) begin errors++; $display("[TB] FAIL reset_rresp: got %b want 00", rresp); end
        if (bresp   !== 2'b00) begin errors++; $display("[TB] FAIL reset_bresp: got %b want 00", bresp); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        for (int i = 0; i < DEPTH; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) d = 64'hDEAD_BEEF_0000_0013;
            if (i == 1) d = 64'h0;
            do_write(BASE + 64'(i * 8), d, 8'hFF, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r, lat);
            model[i] = d;
            checks += 2;
            if (r !== 2'b00) begin errors++; $display("[TB] FAIL fill_bresp[%0d]: got %b want 00", i, r); end
            if (lat != WR_LAT) begin errors++; $display("[TB] FAIL fill_latency[%0d]: got %0d want %0d", i, lat, WR_LAT); end
        end
    endtask

    task automatic test_single_read();
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        do_read(BASE, d, r, lat);
        checks += 3;
        if (d !== 64'hDEAD_BEEF_0000_0013) begin errors++; $display("[TB] FAIL single_rdata: got %h want deadbeef00000013", d); end
        if (r !== 2'b00) begin errors++; $display("[TB] FAIL single_rresp: got %b want 00", r); end
        if (lat != RD_LAT) begin errors++; $display("[TB] FAIL single_latency: got %0d want %0d", lat, RD_LAT); end
    endtask

    task automatic test_write_readback();
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(BASE + 64'h8, 64'h1122_3344_5566_7788, 8'h0F, 0, 1, r, lat);
        model_write(BASE + 64'h8, 64'h1122_3344_5566_7788, 8'h0F);
        checks += 2;
        if (r !== 2'b00) begin errors++; $display("[TB] FAIL wb_bresp: got %b want 00", r); end
        if (lat != WR_LAT) begin errors++; $display("[TB] FAIL wb_latency: got %0d want %0d", lat, WR_LAT); end
        do_read(BASE + 64'h8, d, r, lat);
        checks += 2;
        if (d !== 64'h0000_0000_5566_7788) begin errors++; $display("[TB] FAIL wb_rdata: got %h want 0000000055667788", d); end
        if (r !== 2'b00) begin errors++; $display("[TB] FAIL wb_rresp: got %b want 00", r); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp0, exp1;
        int          guard;
        exp0 = model[5];
        exp1 = model[6];
        araddr  = BASE + 64'(5 * 8);
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        guard = 0;
        while (!rvalid && guard < 50) begin @(posedge clk); #1; guard++; end
        araddr  = BASE + 64'(6 * 8);
        arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks += 3;
            if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_rvalid[%0d]: got %b want 1", c, rvalid); end
            if (rdata !== exp0) begin errors++; $display("[TB] FAIL bp_rdata[%0d]: got %h want %h", c, rdata, exp0); end
            if (arready !== 1'b0) begin errors++; $display("[TB] FAIL bp_arready[%0d]: got %b want 0", c, arready); end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checks++;
        if (arready !== 1'b1) begin errors++; $display("[TB] FAIL bp_arready_after: got %b want 1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        guard = 0;
        while (!rvalid && guard < 50) begin @(posedge clk); #1; guard++; end
        checks++;
        if (rdata !== exp1) begin errors++; $display("[TB] FAIL bp_second_rdata: got %h want %h", rdata, exp1); end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        do_read(64'h7FFF_FFF8, d, r, lat);
        checks += 2;
        if (d !== 64'h0) begin errors++; $display("[TB] FAIL oor_low_rdata: got %h want 0", d); end
        if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_low_rresp: got %b want 10", r); end
        do_read(BASE + 64'(DEPTH * 8), d, r, lat);
        checks += 2;
        if (d !== 64'h0) begin errors++; $display("[TB] FAIL oor_high_rdata: got %h want 0", d); end
        if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_high_rresp: got %b want 10", r); end
        do_write(BASE + 64'(DEPTH * 8), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 0, r, lat);
        checks++;
        if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_bresp: got %b want 10", r); end
        do_write(BASE + 64'(9 * 8), 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, r, lat);
        checks++;
        if (r !== 2'b00) begin errors++; $display("[TB] FAIL zero_strb_bresp: got %b want 00", r); end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(BASE + 64'(i * 8), d, r, lat);
            checks++;
            if (d !== model[i]) begin errors++; $display("[TB] FAIL scan[%0d]: got %h want %h", i, d, model[i]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, d, exp_d;
        logic [7:0]  s;
        logic [1:0]  r, exp_r;
        int          lat, idx;
        for (int n = 0; n < 60; n++) begin
            idx = int'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 7))
                0: a = BASE - 64'((idx + 1) * 8);
                1: a = BASE + 64'((DEPTH + idx) * 8);
                default: a = BASE + 64'(idx * 8) + 64'($urandom_range(0, 7));
            endcase
            exp_r = model_in_range(a) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom};
                s = 8'($urandom);
                do_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r, lat);
                model_write(a, d, s);
                checks++;
                if (r !== exp_r) begin errors++; $display("[TB] FAIL rand_bresp[%0d]: got %b want %b", n, r, exp_r); end
            end else begin
                exp_d = model_in_range(a) ? model[model_idx(a)] : 64'h0;
                do_read(a, d, r, lat);
                checks += 2;
                if (d !== exp_d) begin errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", n, d, exp_d); end
                if (r !== exp_r) begin errors++; $display("[TB] FAIL rand_rresp[%0d]: got %b want %b", n, r, exp_r); end
            end
        end
    endtask

    task automatic test_collision();
        logic [63:0] d, rd;
        logic [1:0]  r;
        int          lat;
        logic        got_r, got_b;
        do_write(BASE + 64'(3 * 8), 64'hA, 8'hFF, 0, 0, r, lat);
        model[3] = 64'hA;
        rready  = 1'b1;
        bready  = 1'b1;
        araddr  = BASE + 64'(3 * 8);
        awaddr  = BASE + 64'(3 * 8);
        wdata   = 64'hB;
        wstrb   = 8'hFF;
        arvalid = 1'b1;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        got_r = 1'b0; got_b = 1'b0; rd = '0;
        for (int c = 1; c <= 20 && !(got_r && got_b); c++) begin
            @(posedge clk); #1;
            if (rvalid && !got_r) begin got_r = 1'b1; rd = rdata; end
            if (bvalid && !got_b) got_b = 1'b1;
        end
        @(posedge clk); #1;
        rready = 1'b0;
        bready = 1'b0;
        model[3] = 64'hB;
        checks += 3;
        if (!(got_r && got_b)) begin errors++; $display("[TB] FAIL coll_handshake: r=%b b=%b want 1 1", got_r, got_b); end
        if (rd !== 64'hA) begin errors++; $display("[TB] FAIL coll_old_data: got %h want a", rd); end
        do_read(BASE + 64'(3 * 8), d, r, lat);
        if (d !== 64'hB) begin errors++; $display("[TB] FAIL coll_new_data: got %h want b", d); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(BASE + 64'(2 * 8), 64'h5, 8'hFF, 0, 0, r, lat);
        model[2] = 64'h5;
        awaddr  = BASE + 64'(2 * 8);
        wdata   = 64'h77;
        wstrb   = 8'hFF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 3;
        if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bvalid: got %b want 0", bvalid); end
        if (awready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_awready: got %b want 1", awready); end
        if (wready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_wready: got %b want 1", wready); end
        @(posedge clk); #1;
        do_read(BASE + 64'(2 * 8), d, r, lat);
        checks++;
        if (d !== 64'h5) begin errors++; $display("[TB] FAIL midrst_mem: got %h want 5", d); end
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        arvalid = 1'b0; rready = 1'b0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0;
        test_reset();
        test_fill();
        test_single_read();
        test_write_readback();
        test_backpressure();
        test_out_of_range();
        test_random();
        test_collision();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
